// File: rtl/elevator_pkg.sv
// Shared types and default timing constants for the elevator car controller
// and its helper blocks.
package elevator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UP    = 3'd1,
        ST_DOWN  = 3'd2,
        ST_OPEN  = 3'd3,
        ST_CLOSE = 3'd4
    } state_t;

    localparam int DEF_NUM_FLOORS  = 8;
    localparam int DEF_FLOOR_TICKS = 4;
    localparam int DEF_DOOR_TICKS  = 8;
    localparam int DEF_CLOSE_TICKS = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/elevator_call_scan.sv
// Classifies the outstanding calls relative to a floor: any above, any below,
// and whether the floor itself is called.
module elevator_call_scan
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    output logic                  above_o,
    output logic                  below_o,
    output logic                  here_o
);

    localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

    logic [NUM_FLOORS-1:0] here_mask;
    logic [NUM_FLOORS-1:0] below_mask;
    logic [NUM_FLOORS-1:0] above_mask;

    // Thermometer masks: everything under the floor's one-hot bit is "below".
    assign here_mask  = ONE << floor_i;
    assign below_mask = here_mask - ONE;
    assign above_mask = ~(below_mask | here_mask);

    assign here_o  = |(pending_i & here_mask);
    assign below_o = |(pending_i & below_mask);
    assign above_o = |(pending_i & above_mask);

endmodule

// File: rtl/elevator_ctrl_n.sv
// Single-car elevator controller: latches calls and serves them with a SCAN
// policy, timed floor travel and a door dwell/close sequence.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int FLOOR_TICKS = DEF_FLOOR_TICKS,
    parameter int DOOR_TICKS  = DEF_DOOR_TICKS,
    parameter int CLOSE_TICKS = DEF_CLOSE_TICKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req_i,
    input  logic                  door_open_i,
    input  logic                  door_close_i,
    input  logic                  overload_i,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic [FLOOR_W-1:0]    floor_o,
    output logic                  dir_up_o,
    output logic                  moving_up_o,
    output logic                  moving_down_o,
    output logic                  door_open_o,
    output logic                  door_closing_o
);

    localparam int TIMER_W = $clog2(max3(FLOOR_TICKS, DOOR_TICKS, CLOSE_TICKS) + 1);

    typedef logic [TIMER_W-1:0] timer_t;

    localparam timer_t                  FLOOR_LAST = timer_t'(FLOOR_TICKS - 1);
    localparam timer_t                  DOOR_LAST  = timer_t'(DOOR_TICKS - 1);
    localparam timer_t                  CLOSE_LAST = timer_t'(CLOSE_TICKS - 1);
    localparam logic [FLOOR_W-1:0]      TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0]   ONE        = NUM_FLOORS'(1);

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    timer_t                timer_q, timer_d;

    logic [FLOOR_W-1:0]    floor_arr;
    logic [NUM_FLOORS-1:0] cur_hot;
    logic [NUM_FLOORS-1:0] arr_hot;
    logic [NUM_FLOORS-1:0] req_seen;
    logic                  above, below, here;
    logic                  arr_above, arr_below, arr_here;
    logic                  door_state;
    logic                  reopen;
    logic                  at_end;

    assign cur_hot    = ONE << floor_q;
    assign floor_arr  = (state_q == ST_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    assign arr_hot    = ONE << floor_arr;
    assign req_seen   = pending_q | req_i;
    assign door_state = (state_q == ST_OPEN) || (state_q == ST_CLOSE);
    assign reopen     = door_open_i | overload_i | (|(req_i & cur_hot));
    assign at_end     = ((state_q == ST_UP) && (floor_q == TOP_FLOOR)) ||
                        ((state_q == ST_DOWN) && (floor_q == '0));

    elevator_call_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_cur (
        .pending_i (pending_q),
        .floor_i   (floor_q),
        .above_o   (above),
        .below_o   (below),
        .here_o    (here)
    );

    // Looks at the floor being arrived at, including calls pressed this cycle,
    // so an arrival decision needs no extra cycle.
    elevator_call_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_arr (
        .pending_i (req_seen),
        .floor_i   (floor_arr),
        .above_o   (arr_above),
        .below_o   (arr_below),
        .here_o    (arr_here)
    );

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        timer_d   = timer_q + timer_t'(1);
        pending_d = pending_q | (door_state ? (req_i & ~cur_hot) : req_i);

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (door_open_i || here) begin
                    state_d   = ST_OPEN;
                    pending_d = pending_d & ~cur_hot;
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = ST_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = ST_DOWN;
                    dir_up_d = 1'b0;
                end
            end

            ST_UP, ST_DOWN: begin
                if (timer_q == FLOOR_LAST) begin
                    timer_d = '0;
                    if (at_end) begin
                        state_d = ST_IDLE;
                    end else begin
                        floor_d = floor_arr;
                        if (arr_here) begin
                            state_d   = ST_OPEN;
                            pending_d = pending_d & ~arr_hot;
                        end else if (!((state_q == ST_UP) ? arr_above : arr_below)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_OPEN: begin
                // Hold requests beat the close button, so open+close keeps the door open.
                if (reopen) begin
                    timer_d = '0;
                end else if (door_close_i || (timer_q == DOOR_LAST)) begin
                    state_d = ST_CLOSE;
                    timer_d = '0;
                end
            end

            ST_CLOSE: begin
                if (reopen) begin
                    state_d   = ST_OPEN;
                    timer_d   = '0;
                    pending_d = pending_d & ~cur_hot;
                end else if (timer_q == CLOSE_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            pending_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

    assign pending_o      = pending_q;
    assign floor_o        = floor_q;
    assign dir_up_o       = dir_up_q;
    assign moving_up_o    = (state_q == ST_UP);
    assign moving_down_o  = (state_q == ST_DOWN);
    assign door_open_o    = (state_q == ST_OPEN);
    assign door_closing_o = (state_q == ST_CLOSE);

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Scoreboard bench for elevator_ctrl_n: a countdown-based car model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_elevator_ctrl_n;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int FT = 4;
    localparam int DT = 8;
    localparam int CT = 2;

    localparam int M_IDLE  = 0;
    localparam int M_UP    = 1;
    localparam int M_DOWN  = 2;
    localparam int M_OPEN  = 3;
    localparam int M_CLOSE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NF-1:0] req_i = '0;
    logic          door_open_i = 1'b0;
    logic          door_close_i = 1'b0;
    logic          overload_i = 1'b0;
    logic [NF-1:0] pending_o;
    logic [FW-1:0] floor_o;
    logic          dir_up_o;
    logic          moving_up_o;
    logic          moving_down_o;
    logic          door_open_o;
    logic          door_closing_o;

    elevator_ctrl_n #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .FLOOR_TICKS (FT),
        .DOOR_TICKS  (DT),
        .CLOSE_TICKS (CT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .door_open_i    (door_open_i),
        .door_close_i   (door_close_i),
        .overload_i     (overload_i),
        .pending_o      (pending_o),
        .floor_o        (floor_o),
        .dir_up_o       (dir_up_o),
        .moving_up_o    (moving_up_o),
        .moving_down_o  (moving_down_o),
        .door_open_o    (door_open_o),
        .door_closing_o (door_closing_o)
    );

    always #5 clk = ~clk;

    int unsigned posedges = 0;
    always @(posedge clk) posedges <= posedges + 1;

    typedef struct {
        int unsigned   due;
        logic [NF-1:0] pend;
        int            fl;
        logic          dir;
        logic [3:0]    flags;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_bound(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got wait-bound expiry expected DUT event at %0t", name, $time);
    endfunction

    // Reference model: calls as a set, timers as countdowns of remaining cycles.
    int m_mode;
    int m_left;
    int m_fl;
    bit m_dir;
    bit m_calls[NF];

    function automatic void m_reset();
        m_mode = M_IDLE;
        m_left = 0;
        m_fl   = 0;
        m_dir  = 1'b1;
        for (int k = 0; k < NF; k++) m_calls[k] = 1'b0;
    endfunction

    function automatic bit any_dir(input bit up);
        for (int k = 0; k < NF; k++)
            if (m_calls[k] && (up ? (k > m_fl) : (k < m_fl))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_open();
        m_mode = M_OPEN;
        m_left = DT;
        m_calls[m_fl] = 1'b0;
    endfunction

    function automatic void m_step(input logic rst_v, input logic [NF-1:0] r,
                                   input logic dop, input logic dcl, input logic ovl);
        bit old_here, old_up, old_dn, doors, reopen;
        int nf;
        if (!rst_v) begin
            m_reset();
            return;
        end
        old_here = m_calls[m_fl];
        old_up   = any_dir(1'b1);
        old_dn   = any_dir(1'b0);
        doors    = (m_mode == M_OPEN) || (m_mode == M_CLOSE);
        reopen   = dop || ovl || r[m_fl];
        for (int k = 0; k < NF; k++)
            if (r[k] && !(doors && k == m_fl)) m_calls[k] = 1'b1;
        case (m_mode)
            M_IDLE: begin
                if (dop || old_here) m_open();
                else if (old_up && (m_dir || !old_dn)) begin
                    m_mode = M_UP; m_dir = 1'b1; m_left = FT;
                end else if (old_dn) begin
                    m_mode = M_DOWN; m_dir = 1'b0; m_left = FT;
                end
            end
            M_UP, M_DOWN: begin
                m_left--;
                if (m_left == 0) begin
                    nf = (m_mode == M_UP) ? m_fl + 1 : m_fl - 1;
                    if (nf < 0 || nf >= NF) m_mode = M_IDLE;
                    else begin
                        m_fl = nf;
                        if (m_calls[m_fl]) m_open();
                        else if (any_dir(m_mode == M_UP)) m_left = FT;
                        else m_mode = M_IDLE;
                    end
                end
            end
            M_OPEN: begin
                if (reopen) m_left = DT;
                else if (dcl) begin
                    m_mode = M_CLOSE; m_left = CT;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_CLOSE; m_left = CT;
                    end
                end
            end
            M_CLOSE: begin
                if (reopen) m_open();
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
            default: m_reset();
        endcase
    endfunction

    function automatic logic [NF-1:0] m_pend();
        logic [NF-1:0] p;
        for (int k = 0; k < NF; k++) p[k] = m_calls[k];
        return p;
    endfunction

    function automatic logic [3:0] mode_flags(input int md);
        return {md == M_UP, md == M_DOWN, md == M_OPEN, md == M_CLOSE};
    endfunction

    task automatic tick_r(input logic rst_v, input logic [NF-1:0] r,
                          input logic dop, input logic dcl, input logic ovl);
        exp_t e;
        logic was;
        @(negedge clk);
        #2;
        was          = rst;
        rst          = rst_v;
        req_i        = r;
        door_open_i  = dop;
        door_close_i = dcl;
        overload_i   = ovl;
        m_step(rst_v, r, dop, dcl, ovl);
        if (was && !rst_v) begin
            #1;
            chk("async_rst_floor",   32'(floor_o), 0);
            chk("async_rst_dir",     32'(dir_up_o), 1);
            chk("async_rst_pending", 32'(pending_o), 0);
            chk("async_rst_flags",   32'({moving_up_o, moving_down_o, door_open_o, door_closing_o}), 0);
        end
        e.due   = posedges + 1;
        e.pend  = m_pend();
        e.fl    = m_fl;
        e.dir   = m_dir;
        e.flags = mode_flags(m_mode);
        sb.push_back(e);
    endtask

    task automatic tick(input logic [NF-1:0] r, input logic dop, input logic dcl, input logic ovl);
        tick_r(1'b1, r, dop, dcl, ovl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= posedges) begin
                e = sb.pop_front();
                chk("pending", 32'(pending_o), 32'(e.pend));
                chk("floor",   32'(floor_o), e.fl);
                chk("dir_up",  32'(dir_up_o), 32'(e.dir));
                chk("state_flags",
                    32'({moving_up_o, moving_down_o, door_open_o, door_closing_o}), 32'(e.flags));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got time limit expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cnt, ccnt, k, first_stop, second_stop, second_dir, stops;
        logic prev_open;
        logic [NF-1:0] r;
        m_reset();

        // 1: single call to floor 3, door dwell and close lengths
        tick_r(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick_r(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0, 1'b0);
        tick(NF'(8), 1'b0, 1'b0, 1'b0);
        cnt = 0; ccnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick('0, 1'b0, 1'b0, 1'b0);
            if (door_open_o) cnt++;
            if (door_closing_o) ccnt++;
        end
        chk("s1_open_cycles", cnt, DT);
        chk("s1_close_cycles", ccnt, CT);
        chk("s1_final_floor", 32'(floor_o), 3);

        // 2: SCAN order, call 1 arrives while passing 3 on the way to 6
        tick(NF'(64), 1'b0, 1'b0, 1'b0);
        for (k = 0; k < 100; k++) begin
            if (floor_o == 3) break;
            tick('0, 1'b0, 1'b0, 1'b0);
        end
        if (k == 100) fail_bound("s2_reach_floor3");
        tick(NF'(2), 1'b0, 1'b0, 1'b0);
        stops = 0; first_stop = -1; second_stop = -1; second_dir = -1; prev_open = 1'b0;
        for (k = 0; k < 200 && stops < 2; k++) begin
            tick('0, 1'b0, 1'b0, 1'b0);
            if (door_open_o && !prev_open) begin
                if (stops == 0) first_stop = int'(floor_o);
                else begin
                    second_stop = int'(floor_o);
                    second_dir  = int'(dir_up_o);
                end
                stops++;
            end
            prev_open = door_open_o;
        end
        if (stops < 2) fail_bound("s2_two_stops");
        chk("s2_first_stop", first_stop, 6);
        chk("s2_second_stop", second_stop, 1);
        chk("s2_dir_at_second", second_dir, 0);
        idle(20);

        // 3: call at the current floor, dwell restarted by a repeat call
        tick(NF'(4), 1'b0, 1'b0, 1'b0);
        idle(30);
        tick(NF'(4), 1'b0, 1'b0, 1'b0);
        for (k = 0; k < 10; k++) begin
            tick('0, 1'b0, 1'b0, 1'b0);
            if (door_open_o) break;
        end
        if (k == 10) fail_bound("s3_open");
        cnt = 1;
        for (int i = 0; i < 3; i++) begin
            tick('0, 1'b0, 1'b0, 1'b0);
            if (door_open_o) cnt++;
        end
        tick(NF'(4), 1'b0, 1'b0, 1'b0);
        if (door_open_o) cnt++;
        for (k = 0; k < 30; k++) begin
            tick('0, 1'b0, 1'b0, 1'b0);
            if (!door_open_o) break;
            cnt++;
        end
        if (k == 30) fail_bound("s3_close");
        chk("s3_open_total", cnt, 13);
        chk("s3_floor", 32'(floor_o), 2);
        idle(10);

        // 4: overload hold with close button ignored, then a clean dwell
        tick('0, 1'b1, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick('0, 1'b0, (i % 3) == 0, 1'b1);
            if (door_open_o) cnt++;
        end
        chk("s4_open_during_overload", cnt, 20);
        cnt = 0;
        for (k = 0; k < 30 && m_mode != M_CLOSE; k++) begin
            tick('0, 1'b0, 1'b0, 1'b0);
            if (door_open_o) cnt++;
        end
        chk("s4_dwell_after_release", cnt, DT);

        // 5: reopen in the first closing cycle, then open+close together
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("s5_first_close_cycle", 32'(door_closing_o), 1);
        cnt = 0;
        for (k = 0; k < 30 && m_mode != M_CLOSE; k++) begin
            tick('0, 1'b0, 1'b0, 1'b0);
            if (door_open_o) cnt++;
        end
        chk("s5_reopen_dwell", cnt, DT);
        idle(10);
        tick('0, 1'b1, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b1, 1'b0);
        tick('0, 1'b0, 1'b0, 1'b0);
        chk("s5_open_wins", 32'({door_open_o, door_closing_o}), 32'(2));
        idle(20);

        // 6: reset while travelling down between floors 5 and 4
        tick(NF'(32), 1'b0, 1'b0, 1'b0);
        for (k = 0; k < 100 && !(m_mode == M_IDLE && m_fl == 5); k++) tick('0, 1'b0, 1'b0, 1'b0);
        if (k == 100) fail_bound("s6_reach_floor5");
        tick(NF'(1), 1'b0, 1'b0, 1'b0);
        for (k = 0; k < 10 && m_mode != M_DOWN; k++) tick('0, 1'b0, 1'b0, 1'b0);
        if (k == 10) fail_bound("s6_start_down");
        idle(2);
        chk("s6_moving_down_pre_rst", 32'({moving_down_o, floor_o}), 32'({1'b1, 3'd5}));
        tick_r(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick_r(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0, 1'b0);
        idle(6);
        chk("s6_idle_after_rst", 32'({moving_up_o, moving_down_o, floor_o}), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = '0;
            for (int b = 0; b < NF; b++) if ($urandom_range(31) == 0) r[b] = 1'b1;
            tick_r($urandom_range(999) != 0, r,
                   $urandom_range(39) == 0, $urandom_range(19) == 0, $urandom_range(59) == 0);
        end
        idle(2);

        @(negedge clk);
        #1;
        if (sb.size() != 0) fail_bound("scoreboard_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
Parametrised elevator car controller for an N-floor shaft. Latches call requests into a pending register and serves them with a SCAN (collective) direction policy. Timed floor travel, timed door dwell with open/close buttons, overload hold and door reopen-on-demand. Drives the motor-direction and door outputs and reports the current floor; sits between the call-button synchronisers and the motor/door actuator drivers.

Parameters:
NUM_FLOORS, 8, number of floors (>=2); floor 0 is ground
FLOOR_W, $clog2(NUM_FLOORS), width of floor index
FLOOR_TICKS, 4, clock cycles to travel one floor (>=1)
DOOR_TICKS, 8, door dwell cycles in OPEN (>=2)
CLOSE_TICKS, 2, door closing cycles in CLOSE (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req_i  in  NUM_FLOORS  call buttons, one bit per floor, sampled every cycle
door_open_i  in  1  door-open button
door_close_i  in  1  door-close button
overload_i  in  1  car overload sensor
pending_o  out  NUM_FLOORS  latched outstanding calls
floor_o  out  FLOOR_W  current floor
dir_up_o  out  1  SCAN direction flag (1 = up)
moving_up_o  out  1  state == UP
moving_down_o  out  1  state == DOWN
door_open_o  out  1  state == OPEN
door_closing_o  out  1  state == CLOSE

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, floor_o=0, dir_up_o=1, pending_o=0, all timers 0, all moving/door outputs 0. Reset mid-travel or with the door open returns to these values immediately. No pending call survives reset.
- Pending register: bit k set on the edge where req_i[k]=1, so it is visible on pending_o the next cycle.
  - Bit floor_o is cleared on entry to OPEN.
  - While in OPEN or CLOSE, req_i[floor_o] is not latched; it restarts the dwell (OPEN) or reopens the door (CLOSE).
- States: IDLE, UP, DOWN, OPEN, CLOSE. All transitions are registered. Helper signals: above = any pending bit > floor_o; below = any pending bit < floor_o.
- IDLE, priority order:
  - door_open_i or pending[floor_o] -> OPEN.
  - above and (dir_up_o or !below) -> UP, dir_up_o<=1.
  - below -> DOWN, dir_up_o<=0.
  - Otherwise stay in IDLE.
- UP/DOWN:
  - Travel timer counts 0..FLOOR_TICKS-1. On the terminal count, floor_o increments (UP) or decrements (DOWN) and the timer clears.
  - On that same edge, next state is OPEN if the new floor's pending bit or req_i bit is set; otherwise remain moving.
  - Calls latched for a floor ahead before arrival are served en route.
  - floor_o never leaves 0..NUM_FLOORS-1. If the target disappears (cannot occur without reset), the car stops at the next floor and enters IDLE.
  - Door buttons are ignored while moving.
- OPEN:
  - Dwell timer counts DOOR_TICKS cycles, then -> CLOSE.
  - door_open_i, overload_i or req_i[floor_o] clears the dwell timer and holds OPEN.
  - door_close_i with no overload -> CLOSE next edge.
  - door_open_i and door_close_i in the same cycle: open wins.
- CLOSE:
  - Counts CLOSE_TICKS cycles, then -> IDLE.
  - door_open_i, overload_i or req_i[floor_o] at any point -> OPEN with a fresh dwell.
- Timer widths: $clog2(max(FLOOR_TICKS, DOOR_TICKS, CLOSE_TICKS)+1). One shared timer is allowed because only one timed state is active at a time. The timer clears on every state change.
- Outputs are decoded from the registered state and registers only; no combinational input-to-output path.

Decomposition:
- Package elevator_pkg: state enum (IDLE, UP, DOWN, OPEN, CLOSE) and the default tick constants.
- Sub-module elevator_call_scan (parametrised NUM_FLOORS): takes pending and floor_o, produces above, below and here. This is the only non-trivial combinational logic and is reused by the future multi-car dispatcher.

Test Plan:
1. Defaults, idle at floor 0; pulse req_i[3] one cycle -> pending_o[3]=1 next cycle, moving_up_o next edge, floor_o 1/2/3 at 4-cycle spacing. Then door_open_o for 8 cycles, pending_o[3]=0, door_closing_o for 2 cycles, then IDLE.
2. SCAN order: car moving up past floor 3 with pending 1 and 6 -> stops at 6 first, then dir_up_o=0 and serves 1. Floor 1 is never visited before 6.
3. Idle at floor 2 with req_i[2] -> OPEN next edge with no movement. A second req_i[2] at dwell cycle 5 -> dwell restarts, door open 13 cycles total.
4. overload_i held high for 20 cycles in OPEN -> door_open_o stays 1 throughout; after release, exactly 8 more cycles before CLOSE. door_close_i during overload is ignored.
5. door_open_i in first CLOSE cycle -> OPEN next edge with full 8-cycle dwell. door_open_i and door_close_i together in OPEN -> remains OPEN.
6. rst=0 asserted while moving down between floors 5 and 4 -> all outputs go to reset values immediately: floor_o=0, dir_up_o=1, pending_o=0. On release, IDLE with no movement.
